// File: rtl/trigger_event_gen.sv
// Debounces four active-low buttons and monitors a counter. Press, release, threshold
// crossing, wrap and overflow events come out as registered pulses plus sticky host flags.
module trigger_event_gen #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic [3:0]  button,
  input  logic [31:0] cnt_value,
  input  logic [31:0] cnt_threshold,
  input  logic [15:0] ack_mask,
  output logic [15:0] trig_out,
  output logic [15:0] sticky,
  output logic [3:0]  btn_state
);

  localparam logic [15:0] LP_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [15:0] r_cnt [4];
  logic [3:0]  r_btn_state;
  logic [3:0]  r_btn_d;
  logic        r_ge_q;
  logic        r_msb_q;
  logic [10:0] r_trig;
  logic [10:0] r_sticky;

  logic [3:0]  w_pressed;
  logic [3:0]  w_press;
  logic [3:0]  w_release;
  logic        w_ge;
  logic        w_thr;
  logic        w_wrap;
  logic        w_ovf;
  logic [10:0] w_evt;
  logic        w_unused_ack;

  // Synchronizers idle at 1 so a released button is not seen as a press after reset.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // The toggle lands on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_btn_state <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_pressed[i] != r_btn_state[i]) begin
          if (r_cnt[i] == LP_LAST) begin
            r_btn_state[i] <= ~r_btn_state[i];
            r_cnt[i]       <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 16'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press   = r_btn_state & ~r_btn_d;
  assign w_release = ~r_btn_state & r_btn_d;
  assign w_ge      = (cnt_value >= cnt_threshold);
  assign w_thr     = w_ge & ~r_ge_q;
  assign w_wrap    = r_msb_q & ~cnt_value[31];
  // An ack arriving with the repeated pulse means the host has seen it: no overflow.
  assign w_ovf     = |(r_trig[9:0] & r_sticky[9:0] & ~ack_mask[9:0]);
  assign w_evt     = {w_ovf, w_wrap, w_thr, w_release, w_press};

  // ge_q resets to 1 so a counter already above threshold does not fire after reset.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_btn_d  <= '0;
      r_ge_q   <= 1'b1;
      r_msb_q  <= 1'b0;
      r_trig   <= '0;
      r_sticky <= '0;
    end else begin
      r_btn_d  <= r_btn_state;
      r_ge_q   <= w_ge;
      r_msb_q  <= cnt_value[31];
      r_trig   <= w_evt;
      r_sticky <= (r_sticky & ~ack_mask[10:0]) | r_trig;
    end
  end

  assign w_unused_ack = ^ack_mask[15:11];

  assign trig_out  = {5'b0, r_trig};
  assign sticky    = {5'b0, r_sticky};
  assign btn_state = r_btn_state;

endmodule

// File: tb/tb_trigger_event_gen.sv
// Directed bench for trigger_event_gen with DEBOUNCE_CYCLES=4: a vector table for the
// counter events plus hand-written debounce, glitch and reset sequences.
module tb_trigger_event_gen;

  logic        clk1;
  logic        reset;
  logic [3:0]  button;
  logic [31:0] cnt_value;
  logic [31:0] cnt_threshold;
  logic [15:0] ack_mask;
  logic [15:0] trig_out;
  logic [15:0] sticky;
  logic [3:0]  btn_state;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic [3:0]  btn;
    logic [31:0] cnt;
    logic [31:0] thr;
    logic [15:0] ack;
    logic [15:0] exp_trig;
    logic [15:0] exp_sticky;
    logic [3:0]  exp_btn;
  } vec_t;

  vec_t vecs[$];

  trigger_event_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk1          (clk1),
    .reset         (reset),
    .button        (button),
    .cnt_value     (cnt_value),
    .cnt_threshold (cnt_threshold),
    .ack_mask      (ack_mask),
    .trig_out      (trig_out),
    .sticky        (sticky),
    .btn_state     (btn_state)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] e_trig,
                           input logic [15:0] e_sticky, input logic [3:0] e_btn);
    check({name, ".trig_out"},  32'(trig_out),  32'(e_trig));
    check({name, ".sticky"},    32'(sticky),    32'(e_sticky));
    check({name, ".btn_state"}, 32'(btn_state), 32'(e_btn));
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    button        = 4'hF;
    cnt_value     = '0;
    cnt_threshold = '0;
    ack_mask      = '0;

    // rst, button, cnt, thr, ack -> trig_out, sticky, btn_state after the next edge
    vecs.push_back('{1'b1, 4'hF, 32'd0,        32'd0,   16'h0000, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd98,       32'd100, 16'h0000, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd99,       32'd100, 16'h0000, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd100,      32'd100, 16'h0000, 16'h0100, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd101,      32'd100, 16'h0000, 16'h0000, 16'h0100, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd40,       32'd50,  16'h0100, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd60,       32'd50,  16'h0000, 16'h0100, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd60,       32'd50,  16'h0000, 16'h0000, 16'h0100, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'd60,       32'd50,  16'h0100, 16'h0000, 16'h0000, 4'h0});
    // counter wrap, then a second wrap while sticky[9] is still pending
    vecs.push_back('{1'b0, 4'hF, 32'hFFFFFFFF, 32'd0,   16'h0000, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0200, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'hFFFFFFFF, 32'd0,   16'h0000, 16'h0000, 16'h0200, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0200, 16'h0200, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0400, 16'h0200, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0000, 16'h0600, 4'h0});
    // ack arriving together with a new wrap pulse: set wins, no overflow
    vecs.push_back('{1'b0, 4'hF, 32'hFFFFFFFF, 32'd0,   16'h0000, 16'h0000, 16'h0600, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0200, 16'h0600, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0200, 16'h0000, 16'h0600, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0600, 16'h0000, 16'h0000, 4'h0});
    vecs.push_back('{1'b0, 4'hF, 32'h00000000, 32'd0,   16'h0000, 16'h0000, 16'h0000, 4'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].rst;
      button        = vecs[i].btn;
      cnt_value     = vecs[i].cnt;
      cnt_threshold = vecs[i].thr;
      ack_mask      = vecs[i].ack;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_trig, vecs[i].exp_sticky, vecs[i].exp_btn);
    end

    // button[0] press: j=0 is the first sampling edge
    button = 4'b1110;
    for (int j = 0; j < 9; j++) begin
      tick();
      check_all($sformatf("press_e%0d", j), (j == 6) ? 16'h0001 : 16'h0000,
                (j >= 7) ? 16'h0001 : 16'h0000, (j >= 5) ? 4'h1 : 4'h0);
    end

    // button[0] release
    button = 4'hF;
    for (int j = 0; j < 9; j++) begin
      tick();
      check_all($sformatf("release_e%0d", j), (j == 6) ? 16'h0010 : 16'h0000,
                (j >= 7) ? 16'h0011 : 16'h0001, (j >= 5) ? 4'h0 : 4'h1);
    end
    ack_mask = 16'h0011;
    tick();
    ack_mask = 16'h0000;
    check_all("ack_press_release", 16'h0000, 16'h0000, 4'h0);

    // glitch on button[2] shorter than the debounce window
    button = 4'b1011;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_all($sformatf("glitch_low%0d", j), 16'h0000, 16'h0000, 4'h0);
    end
    button = 4'hF;
    for (int j = 0; j < 8; j++) begin
      tick();
      check_all($sformatf("glitch_after%0d", j), 16'h0000, 16'h0000, 4'h0);
    end

    // reset mid-debounce while the counter jumps above threshold
    cnt_threshold = 32'd100;
    cnt_value     = 32'd50;
    button        = 4'b1101;
    for (int j = 0; j < 4; j++) tick();
    reset     = 1'b1;
    button    = 4'hF;
    cnt_value = 32'd200;
    tick();
    check_all("reset_mid", 16'h0000, 16'h0000, 4'h0);
    reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      check_all($sformatf("post_reset%0d", j), 16'h0000, 16'h0000, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
